// File: rtl/id_ex_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : id_ex_stage_if                                                |
// | Purpose  : Bundles the ID-side inputs, branch flush, forwarding sources  |
// |            and EX-side outputs of the ID/EX pipeline stage.              |
// | Ports    : master - decode/hazard/forwarding drivers, reads EX outputs   |
// |            slave  - the ID/EX stage itself                               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  // ID side
  logic              id_valid;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [REG_W-1:0]  id_rd;
  logic [4:0]        id_shamt;
  logic [5:0]        id_func;
  logic [1:0]        id_aluop;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [6:0]        id_ctrl;
  logic              flush;

  // Forwarding sources from EX/MEM and MEM/WB
  logic              mem_regwrite;
  logic              wb_regwrite;
  logic [REG_W-1:0]  mem_dst;
  logic [REG_W-1:0]  wb_dst;
  logic [DATA_W-1:0] mem_result;
  logic [DATA_W-1:0] wb_data;

  // EX side
  logic              stall_n;
  logic              ex_valid;
  logic [1:0]        ex_aluop;
  logic [5:0]        ex_func;
  logic [4:0]        ex_shamt;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_W-1:0]  ex_dst;
  logic [4:0]        ex_ctrl;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_shamt, id_func, id_aluop,
           id_rs_data, id_rt_data, id_imm, id_ctrl, flush,
           mem_regwrite, wb_regwrite, mem_dst, wb_dst, mem_result, wb_data,
    input  stall_n, ex_valid, ex_aluop, ex_func, ex_shamt, ex_a, ex_b,
           ex_store_data, ex_dst, ex_ctrl
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_shamt, id_func, id_aluop,
           id_rs_data, id_rt_data, id_imm, id_ctrl, flush,
           mem_regwrite, wb_regwrite, mem_dst, wb_dst, mem_result, wb_data,
    output stall_n, ex_valid, ex_aluop, ex_func, ex_shamt, ex_a, ex_b,
           ex_store_data, ex_dst, ex_ctrl
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : id_ex_stage                                                   |
// | Purpose  : ID/EX pipeline register of the 5-stage MIPS core. Registers   |
// |            decoded operands/control, detects load-use hazards (stall +   |
// |            bubble), squashes on branch flush and optionally forwards     |
// |            EX/MEM and MEM/WB results onto the ALU operands.              |
// | Ports    : clk   - clock, all state on rising edge                       |
// |            rst_n - synchronous active-low reset                          |
// |            bus   - id_ex_stage_if.slave (ID inputs, flush, forwarding    |
// |                    sources, stall_n and ex_* outputs)                    |
// | Config   : define IDEX_FWD_EN to enable operand forwarding               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  wire              clk,
  input  wire              rst_n,
  id_ex_stage_if.slave     bus
);

  // Control word bit positions: {RegWrite, MemtoReg, MemRead, MemWrite,
  // Branch, RegDst, ALUSrc}
  localparam int C_MEMREAD = 4;
  localparam int C_REGDST  = 1;
  localparam int C_ALUSRC  = 0;

  logic              r_valid;
  logic [1:0]        r_aluop;
  logic [5:0]        r_func;
  logic [4:0]        r_shamt;
  logic [REG_W-1:0]  r_rs;
  logic [REG_W-1:0]  r_rt;
  logic [REG_W-1:0]  r_rd;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [6:0]        r_ctrl;

  logic              w_haz;
  logic              w_bubble;
  logic [DATA_W-1:0] w_rs_fwd;
  logic [DATA_W-1:0] w_rt_fwd;

  // Load in EX whose destination (rt) is a source of the instruction in ID.
  // $0 is hard-wired, so it never creates a dependency.
  assign w_haz = bus.id_valid & r_valid & r_ctrl[C_MEMREAD] &
                 (r_rt != '0) &
                 ((r_rt == bus.id_rs) | (r_rt == bus.id_rt));

  // A flush discards the ID instruction anyway, so there is nothing to hold.
  assign bus.stall_n = ~(w_haz & ~bus.flush);
  assign w_bubble    = bus.flush | w_haz;

  always_ff @(posedge clk) begin
    if (!rst_n || w_bubble) begin
      r_valid   <= 1'b0;
      r_aluop   <= 2'b00;
      r_func    <= '0;
      r_shamt   <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_ctrl    <= '0;
    end else begin
      r_valid   <= bus.id_valid;
      r_aluop   <= bus.id_aluop;
      r_func    <= bus.id_func;
      r_shamt   <= bus.id_shamt;
      r_rs      <= bus.id_rs;
      r_rt      <= bus.id_rt;
      r_rd      <= bus.id_rd;
      r_rs_data <= bus.id_rs_data;
      r_rt_data <= bus.id_rt_data;
      r_imm     <= bus.id_imm;
      r_ctrl    <= bus.id_ctrl;
    end
  end

`ifdef IDEX_FWD_EN
  // The younger result in EX/MEM supersedes the one in MEM/WB.
  always_comb begin
    w_rs_fwd = r_rs_data;
    if (bus.mem_regwrite && (bus.mem_dst != '0) && (bus.mem_dst == r_rs))
      w_rs_fwd = bus.mem_result;
    else if (bus.wb_regwrite && (bus.wb_dst != '0) && (bus.wb_dst == r_rs))
      w_rs_fwd = bus.wb_data;
  end

  always_comb begin
    w_rt_fwd = r_rt_data;
    if (bus.mem_regwrite && (bus.mem_dst != '0) && (bus.mem_dst == r_rt))
      w_rt_fwd = bus.mem_result;
    else if (bus.wb_regwrite && (bus.wb_dst != '0) && (bus.wb_dst == r_rt))
      w_rt_fwd = bus.wb_data;
  end
`else
  assign w_rs_fwd = r_rs_data;
  assign w_rt_fwd = r_rt_data;
`endif

  assign bus.ex_valid      = r_valid;
  assign bus.ex_aluop      = r_aluop;
  assign bus.ex_func       = r_func;
  assign bus.ex_shamt      = r_shamt;
  assign bus.ex_a          = w_rs_fwd;
  assign bus.ex_b          = r_ctrl[C_ALUSRC] ? r_imm : w_rt_fwd;
  assign bus.ex_store_data = w_rt_fwd;
  assign bus.ex_dst        = r_ctrl[C_REGDST] ? r_rd : r_rt;
  assign bus.ex_ctrl       = r_ctrl[6:2];

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 5-stage MIPS core, directly upstream of the ALU control and ALU. It registers decoded operands and control at the ID→EX boundary and detects load-use hazards, stalling fetch/decode and injecting a bubble. It also applies branch-flush squashing and, optionally, EX/MEM and MEM/WB operand forwarding. Its outputs drive `ALUOp`/`func` of the ALU control and `A`/`B`/`shift_amt` of the ALU.

## Interface
- DATA_W, 32, operand/immediate width
- REG_W, 5, register-index width
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- id_valid  in  1  ID holds a valid instruction
- id_rs, id_rt, id_rd  in  REG_W each  decoded register indices
- id_shamt  in  5  shift amount
- id_func  in  6  function field
- id_aluop  in  2  ALUOp (00 lw/sw, 01 beq, 10 R-type)
- id_rs_data, id_rt_data  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_ctrl  in  7  {RegWrite, MemtoReg, MemRead, MemWrite, Branch, RegDst, ALUSrc}
- flush  in  1  branch resolved taken; squash instruction entering EX
- mem_regwrite, wb_regwrite  in  1  writeback enables of EX/MEM and MEM/WB
- mem_dst, wb_dst  in  REG_W  destination indices of EX/MEM and MEM/WB
- mem_result, wb_data  in  DATA_W  forwarded values
- stall_n  out  1  0 = hold PC and IF/ID this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_aluop  out  2; ex_func  out  6; ex_shamt  out  5  to ALU control / ALU
- ex_a, ex_b  out  DATA_W  ALU operands (ex_b after ALUSrc mux)
- ex_store_data  out  DATA_W  forwarded rt value for sw
- ex_dst  out  REG_W  rd if RegDst else rt
- ex_ctrl  out  5  {RegWrite, MemtoReg, MemRead, MemWrite, Branch}

## Operation
- Registered fields: valid, aluop, func, shamt, rs, rt, rd, rs_data, rt_data, imm, 7 ctrl bits.
- Hazard (combinational): haz = id_valid & ex_valid & MemRead_q & (rt_q != 0) & (rt_q == id_rs | rt_q == id_rt).
- stall_n = ~(haz & ~flush).
- Per-edge priority: (1) rst_n=0 → all registers zero; (2) flush=1 → bubble; (3) haz=1 → bubble; (4) else load ID fields, valid_q ← id_valid.
- Bubble: all registered fields zero (valid, ctrl, aluop=00, data, indices).
- ex_dst = RegDst_q ? rd_q : rt_q; ex_ctrl = upper 5 ctrl bits; ex_func/ex_shamt/ex_aluop straight from registers.
- ex_b = ALUSrc_q ? imm_q : rt_fwd; ex_a = rs_fwd; ex_store_data = rt_fwd.
- Register index 0 never matches for hazard or forwarding.

## Timing
- Latency 1 cycle ID→EX; ex_* outputs valid after the edge, plus combinational forwarding muxes.
- Reset values: ex_valid=0, ex_ctrl=0, ex_aluop=00, ex_func=0, ex_shamt=0, ex_dst=0, ex_a/ex_b/ex_store_data=0 (when forwarding inputs inactive), stall_n=1.
- Load-use: exactly one stall cycle; following edge loads the held ID instruction (hazard clears as EX holds bubble).
- flush with haz in same cycle: flush wins, stall_n=1, bubble loaded.
- id_valid=0 never stalls; loads valid=0 with its fields.
- rst_n deasserted mid-stall: next edge takes normal priority from zero state (no stall).

## Configuration
- IDEX_FWD_EN defined: rs_fwd = (mem_regwrite & mem_dst!=0 & mem_dst==rs_q) ? mem_result : (wb_regwrite & wb_dst!=0 & wb_dst==rs_q) ? wb_data : rs_data_q; rt_fwd likewise with rt_q. EX/MEM has priority.
- Not defined: rs_fwd = rs_data_q, rt_fwd = rt_data_q; forwarding inputs ignored; hazard logic unchanged.

## Test plan
- Reset: rst_n=0 two edges with random inputs → ex_valid=0, ex_ctrl=0, stall_n=1; release, R-type add (rs=8 data 5, rt=9 data 7, func=32, aluop=10) → next cycle ex_a=5, ex_b=7, ex_func=32, ex_dst=rd.
- Load-use: lw $9 in EX (MemRead=1, rt=9), ID add rs=9 → stall_n=0 one cycle, EX bubble (ex_ctrl=0); next edge add enters EX, stall_n=1.
- Flush+hazard same cycle → stall_n=1, EX holds bubble, ID instruction not loaded.
- Immediate path: ALUSrc=1, imm=0xFFFFFFFC → ex_b=0xFFFFFFFC; RegDst=0 → ex_dst=rt.
- IDEX_FWD_EN: rs_q=8, mem_dst=8 mem_result=0x11, wb_dst=8 wb_data=0x22 → ex_a=0x11; mem_regwrite=0 → ex_a=0x22; dst=0 → no forward.
- Register 0: lw with rt=0 in EX, ID rs=0 → no stall.
